audio_mix_sched: RTL and testbench
==================================

AUDIO_MIX_SCHED -- requirements
Module: audio_mix_sched

Interface
REQ-001 The block SHALL have no parameters; the channel count is fixed at 4.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 smp_tick  input  1  one-cycle strobe requesting one mixed output sample.
REQ-005 ch_sin  input  64  four signed 16-bit samples; ch0 in [15:0] through ch3 in [63:48].
REQ-006 ch_level  input  12  four 3-bit log volume levels; ch0 in [2:0].
REQ-007 ch_en  input  4  per-channel mix enable; bit n is channel n.
REQ-008 master_level  input  3  3-bit log master volume.
REQ-009 sout  output  16  signed mixed sample, registered.
REQ-010 sout_valid  output  1  one-cycle pulse when sout updates.
REQ-011 busy  output  1  high while a mix is in progress (state not IDLE).
REQ-012 clip  output  1  registered with sout; high if that sample saturated.
REQ-013 overrun  output  1  sticky; set when smp_tick arrives while busy.

Function
REQ-014 Gain map SHALL be the level-to-linear map 7->16, 6->14, 5->12, 4->10, 3->8, 2->7, 1->6, 0->5 (units of 1/16).
REQ-015 One shared 16x5 signed-by-unsigned multiplier SHALL serve all channels and the master stage, one use per cycle.
REQ-016 Term = (sample * gain) arithmetic-shifted right 4, a 16-bit signed result; disabled channels contribute 0.
REQ-017 States: IDLE, MIX (channel index 0..3), MASTER.
REQ-018 IDLE + smp_tick at edge E0: latch ch_sin, ch_level, ch_en and master_level, clear the 18-bit signed accumulator, set index 0, go to MIX.
REQ-019 MIX: edges E1..E4 add the term of the current index to the accumulator; the edge at index 3 goes to MASTER.
REQ-020 MASTER edge E5: compute (acc * master gain) arithmetic-shifted right 4; saturate to [-32768, 32767]; load sout and clip; pulse sout_valid; go to IDLE.
REQ-021 Latency: sout_valid SHALL be high in the cycle following E5, i.e. 5 clocks after the accepting edge; maximum throughput is one sample per 6 clocks.
REQ-022 smp_tick sampled in MIX or MASTER SHALL be ignored for mixing and SHALL set overrun; the in-flight mix SHALL be unaffected.
REQ-023 smp_tick sampled in the cycle sout_valid is high (state IDLE) SHALL be accepted normally.
REQ-024 Inputs SHALL be used only from their latched copies; input changes during busy SHALL NOT affect the current sample.
REQ-025 sout and clip SHALL hold their values between sout_valid pulses.

Reset
REQ-026 Reset SHALL force: state IDLE, index 0, accumulator 0, sout 0, sout_valid 0, busy 0, clip 0, overrun 0, and ramp levels 0.
REQ-027 Reset asserted mid-mix SHALL abort the mix with no sout_valid pulse; a tick in the same cycle as reset SHALL be ignored.

Configuration
REQ-028 Macro MIX_SOFTRAMP_EN SHALL select the soft-ramp feature.
REQ-029 With MIX_SOFTRAMP_EN defined: each channel keeps a 3-bit current level; at each accepted tick it steps by 1 toward ch_level (or holds if equal); the stepped value is the one used for that sample.
REQ-030 Without MIX_SOFTRAMP_EN: the latched ch_level SHALL be used directly, and no ramp registers SHALL exist.
REQ-031 The master level SHALL never ramp.

Verification
REQ-032 Single channel: ch0=0x1000, level 7, ch_en=0001, master 7, tick -> sout=0x1000, clip 0, valid 5 clocks after tick. With level 0 -> sout=0x0500 (no ramp build).
REQ-033 Positive saturation: all channels 0x7FFF, level 7, ch_en=1111, master 7 -> sout=0x7FFF, clip=1. All channels 0x8000 -> sout=0x8000, clip=1.
REQ-034 Master scaling: ch0=0x2000 and ch1=0x2000, level 7, master 3 -> acc 0x4000, sout=0x2000, clip 0.
REQ-035 Overrun: tick 2 clocks after an accepted tick -> overrun=1 and exactly one sout_valid pulse; a tick on the valid cycle is accepted -> second valid 6 clocks after the first.
REQ-036 Reset at E3 -> no valid pulse, all outputs 0, next tick mixes correctly. With MIX_SOFTRAMP_EN, ch0 level 7 from reset gives gains 6, 7, 8, 10, ... on successive ticks; ch0=0x1000 -> sout 0x0600, 0x0700, 0x0800, 0x0A00.

Source files
------------

// File: rtl/audio_mix_sched.sv
`default_nettype none
// ============================================================================
// Module   : audio_mix_sched
// Purpose  : Four-channel audio mixer with log volume per channel and a log
//            master volume. A single shared multiplier is time-multiplexed
//            over the four channel terms and then the master stage, so one
//            output sample takes five clocks after the tick that starts it.
//            Optional soft ramp of channel levels: define MIX_SOFTRAMP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module audio_mix_sched (
    input  logic        clk,
    input  logic        reset,
    input  logic        smp_tick,
    input  logic [63:0] ch_sin,
    input  logic [11:0] ch_level,
    input  logic [3:0]  ch_en,
    input  logic [2:0]  master_level,
    output logic [15:0] sout,
    output logic        sout_valid,
    output logic        busy,
    output logic        clip,
    output logic        overrun
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MIX    = 2'd1,
        S_MASTER = 2'd2
    } state_t;

    localparam logic signed [23:0] C_SAT_MAX = 24'sd32767;
    localparam logic signed [23:0] C_SAT_MIN = -24'sd32768;

    // Log level to linear gain in sixteenths.
    function automatic logic [4:0] gain_of(input logic [2:0] lvl);
        logic [4:0] g;
        case (lvl)
            3'd7:    g = 5'd16;
            3'd6:    g = 5'd14;
            3'd5:    g = 5'd12;
            3'd4:    g = 5'd10;
            3'd3:    g = 5'd8;
            3'd2:    g = 5'd7;
            3'd1:    g = 5'd6;
            default: g = 5'd5;
        endcase
        return g;
    endfunction

    state_t             r_state;
    logic [1:0]         r_idx;
    logic signed [17:0] r_acc;
    logic [3:0][15:0]   r_sin;
    logic [3:0][2:0]    r_lvl;
    logic [3:0]         r_en;
    logic [2:0]         r_mlvl;

    // Channel levels that get latched by an accepted tick.
    logic [3:0][2:0]    w_lvl_next;

`ifdef MIX_SOFTRAMP_EN
    logic [3:0][2:0]    r_ramp;
    logic [3:0][2:0]    w_step;
    logic [3:0][2:0]    w_target;

    assign w_target = ch_level;

    // Each channel level moves one step toward its requested level per tick.
    always_comb begin
        w_step = r_ramp;
        for (int n = 0; n < 4; n++) begin
            if (r_ramp[n] < w_target[n])
                w_step[n] = r_ramp[n] + 3'd1;
            else if (r_ramp[n] > w_target[n])
                w_step[n] = r_ramp[n] - 3'd1;
        end
    end

    // Ramp state advances only on ticks the scheduler accepts.
    always_ff @(posedge clk) begin
        if (reset)
            r_ramp <= '0;
        else if (r_state == S_IDLE && smp_tick)
            r_ramp <= w_step;
    end

    assign w_lvl_next = w_step;
`else
    assign w_lvl_next = ch_level;
`endif

    // Shared multiplier. The channel sample is sign-extended onto the same
    // 18-bit operand that carries the accumulator during the master stage,
    // so one multiplier covers both uses.
    logic signed [17:0] w_mul_a;
    logic [4:0]         w_mul_g;
    logic signed [23:0] w_prod;
    logic signed [23:0] w_shift;
    logic signed [15:0] w_term;

    // Operand select: accumulator in MASTER, current channel otherwise.
    always_comb begin
        if (r_state == S_MASTER) begin
            w_mul_a = r_acc;
            w_mul_g = gain_of(r_mlvl);
        end else begin
            w_mul_a = {{2{r_sin[r_idx][15]}}, r_sin[r_idx]};
            w_mul_g = r_en[r_idx] ? gain_of(r_lvl[r_idx]) : 5'd0;
        end
    end

    assign w_prod  = w_mul_a * $signed({1'b0, w_mul_g});
    assign w_shift = w_prod >>> 4;
    assign w_term  = w_shift[15:0];

    assign busy = (r_state != S_IDLE);

    // Mix scheduler: accept, four channel accumulations, master and saturate.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_idx      <= 2'd0;
            r_acc      <= '0;
            r_sin      <= '0;
            r_lvl      <= '0;
            r_en       <= '0;
            r_mlvl     <= '0;
            sout       <= '0;
            sout_valid <= 1'b0;
            clip       <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            sout_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (smp_tick) begin
                        r_sin   <= ch_sin;
                        r_lvl   <= w_lvl_next;
                        r_en    <= ch_en;
                        r_mlvl  <= master_level;
                        r_acc   <= '0;
                        r_idx   <= 2'd0;
                        r_state <= S_MIX;
                    end
                end
                S_MIX: begin
                    if (smp_tick)
                        overrun <= 1'b1;
                    r_acc <= r_acc + {{2{w_term[15]}}, w_term};
                    if (r_idx == 2'd3) begin
                        r_idx   <= 2'd0;
                        r_state <= S_MASTER;
                    end else begin
                        r_idx <= r_idx + 2'd1;
                    end
                end
                S_MASTER: begin
                    if (smp_tick)
                        overrun <= 1'b1;
                    if (w_shift > C_SAT_MAX) begin
                        sout <= 16'h7FFF;
                        clip <= 1'b1;
                    end else if (w_shift < C_SAT_MIN) begin
                        sout <= 16'h8000;
                        clip <= 1'b1;
                    end else begin
                        sout <= w_shift[15:0];
                        clip <= 1'b0;
                    end
                    sout_valid <= 1'b1;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_audio_mix_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_mix_sched
// Purpose  : Directed self-checking bench for audio_mix_sched.
// Revision : 1.0 - initial release
// ============================================================================
module tb_audio_mix_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        smp_tick = 1'b0;
    logic [63:0] ch_sin = '0;
    logic [11:0] ch_level = '0;
    logic [3:0]  ch_en = '0;
    logic [2:0]  master_level = '0;
    logic [15:0] sout;
    logic        sout_valid;
    logic        busy;
    logic        clip;
    logic        overrun;

    int tests_run = 0;
    int tests_failed = 0;

    audio_mix_sched dut (
        .clk          (clk),
        .reset        (reset),
        .smp_tick     (smp_tick),
        .ch_sin       (ch_sin),
        .ch_level     (ch_level),
        .ch_en        (ch_en),
        .master_level (master_level),
        .sout         (sout),
        .sout_valid   (sout_valid),
        .busy         (busy),
        .clip         (clip),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits up to 12 cycles for sout_valid; lat=0 means it never came.
    task automatic wait_valid(output int lat);
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (sout_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic count_valid(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (sout_valid) cnt++;
        end
    endtask

    task automatic set_inputs(input logic [63:0] s, input logic [11:0] l,
                              input logic [3:0] e, input logic [2:0] m);
        ch_sin = s;
        ch_level = l;
        ch_en = e;
        master_level = m;
    endtask

    // Issue one tick with the given inputs and check the resulting sample.
    task automatic do_mix(input string tag, input logic [63:0] s, input logic [11:0] l,
                          input logic [3:0] e, input logic [2:0] m,
                          input logic [15:0] exp_sout, input logic exp_clip);
        int lat;
        @(negedge clk);
        set_inputs(s, l, e, m);
        smp_tick = 1'b1;
        @(negedge clk);
        smp_tick = 1'b0;
        wait_valid(lat);
        check({tag, "_latency"}, lat, 5);
        check({tag, "_sout"}, {16'h0, sout}, {16'h0, exp_sout});
        check({tag, "_clip"}, {31'h0, clip}, {31'h0, exp_clip});
    endtask

    initial begin
        int lat;
        int cnt;

        // Reset state
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_sout", {16'h0, sout}, 32'h0);
        check("rst_valid", {31'h0, sout_valid}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_clip", {31'h0, clip}, 32'h0);
        check("rst_overrun", {31'h0, overrun}, 32'h0);

`ifdef MIX_SOFTRAMP_EN
        // Ramp from level 0 toward 7: gains 6, 7, 8, 10, 12
        do_mix("ramp1", 64'h0000_0000_0000_1000, 12'o0007, 4'b0001, 3'd7, 16'h0600, 1'b0);
        do_mix("ramp2", 64'h0000_0000_0000_1000, 12'o0007, 4'b0001, 3'd7, 16'h0700, 1'b0);
        do_mix("ramp3", 64'h0000_0000_0000_1000, 12'o0007, 4'b0001, 3'd7, 16'h0800, 1'b0);
        do_mix("ramp4", 64'h0000_0000_0000_1000, 12'o0007, 4'b0001, 3'd7, 16'h0A00, 1'b0);
        do_mix("ramp5", 64'h0000_0000_0000_1000, 12'o0007, 4'b0001, 3'd7, 16'h0C00, 1'b0);
        // Step back down from 5 toward 0: level 4 gives gain 10
        do_mix("ramp_dn", 64'h0000_0000_0000_1000, 12'o0000, 4'b0001, 3'd7, 16'h0A00, 1'b0);
`else
        // Single channel, full and minimum level
        do_mix("single_l7", 64'h0000_0000_0000_1000, 12'o0007, 4'b0001, 3'd7, 16'h1000, 1'b0);
        do_mix("single_l0", 64'h0000_0000_0000_1000, 12'o0000, 4'b0001, 3'd7, 16'h0500, 1'b0);

        // Saturation both directions
        do_mix("sat_pos", 64'h7FFF_7FFF_7FFF_7FFF, 12'o7777, 4'b1111, 3'd7, 16'h7FFF, 1'b1);
        do_mix("sat_neg", 64'h8000_8000_8000_8000, 12'o7777, 4'b1111, 3'd7, 16'h8000, 1'b1);

        // Master scaling: acc 0x4000, gain 8 -> 0x2000; clip returns low
        do_mix("master", 64'h0000_0000_2000_2000, 12'o0077, 4'b0011, 3'd3, 16'h2000, 1'b0);
        repeat (4) @(negedge clk);
        check("hold_sout", {16'h0, sout}, 32'h2000);
        check("hold_clip", {31'h0, clip}, 32'h0);

        // Only ch2 enabled: -256 * 10 >>> 4 = -160
        do_mix("enable_mask", 64'h7FFF_FF00_7FFF_7FFF, 12'o7477, 4'b0100, 3'd7, 16'hFF60, 1'b0);

        // Mixed levels: 192 + 7 + (-6) + 1 = 194; * 5 >>> 4 = 60
        do_mix("mixed", 64'h0003_FFF1_0010_0100, {3'd3, 3'd1, 3'd2, 3'd5}, 4'b1111, 3'd0,
               16'h003C, 1'b0);

        // Inputs changing while busy must not disturb the latched sample
        @(negedge clk);
        set_inputs(64'h0000_0000_0000_1000, 12'o0007, 4'b0001, 3'd7);
        smp_tick = 1'b1;
        @(negedge clk);
        smp_tick = 1'b0;
        set_inputs(64'h7FFF_7FFF_7FFF_0123, 12'o0000, 4'b1111, 3'd0);
        wait_valid(lat);
        check("latch_latency", lat, 5);
        check("latch_sout", {16'h0, sout}, 32'h1000);

        // Overrun: second tick 2 clocks after the accepted one
        check("pre_overrun", {31'h0, overrun}, 32'h0);
        @(negedge clk);
        set_inputs(64'h0000_0000_0000_0200, 12'o0007, 4'b0001, 3'd7);
        smp_tick = 1'b1;
        @(negedge clk);
        smp_tick = 1'b0;
        @(negedge clk);
        smp_tick = 1'b1;
        set_inputs(64'h0000_0000_0000_0300, 12'o0007, 4'b0001, 3'd7);
        @(negedge clk);
        smp_tick = 1'b0;
        count_valid(12, cnt);
        check("ovr_pulses", cnt, 1);
        check("ovr_flag", {31'h0, overrun}, 32'h1);
        check("ovr_sout", {16'h0, sout}, 32'h0200);

        // Tick on the valid cycle is accepted; next valid 6 clocks later
        @(negedge clk);
        set_inputs(64'h0000_0000_0000_0400, 12'o0007, 4'b0001, 3'd7);
        smp_tick = 1'b1;
        @(negedge clk);
        smp_tick = 1'b0;
        wait_valid(lat);
        check("b2b_lat1", lat, 5);
        check("b2b_sout1", {16'h0, sout}, 32'h0400);
        set_inputs(64'h0000_0000_0000_0100, 12'o0007, 4'b0001, 3'd7);
        smp_tick = 1'b1;
        @(negedge clk);
        smp_tick = 1'b0;
        wait_valid(lat);
        check("b2b_lat2", lat + 1, 6);
        check("b2b_sout2", {16'h0, sout}, 32'h0100);

        // Reset at E3 aborts the mix; a tick alongside reset is ignored
        @(negedge clk);
        set_inputs(64'h0000_0000_0000_1000, 12'o0007, 4'b0001, 3'd7);
        smp_tick = 1'b1;
        @(negedge clk);
        smp_tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        smp_tick = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        smp_tick = 1'b0;
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_sout", {16'h0, sout}, 32'h0);
        check("abort_overrun", {31'h0, overrun}, 32'h0);
        check("abort_clip", {31'h0, clip}, 32'h0);
        count_valid(8, cnt);
        check("abort_pulses", cnt, 0);
        do_mix("post_abort", 64'h0000_0000_0000_1000, 12'o0007, 4'b0001, 3'd7, 16'h1000, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
